// File: rtl/lutram_array_ctrl_pkg.sv
// Shared constants, FSM state type and expected-bit helper for the LUTRAM self-test sequencer.
package lutram_array_pkg;

  localparam int LUTRAM_ADDR_W = 6;
  localparam int LUTRAM_DEPTH  = 64;
  localparam logic [LUTRAM_ADDR_W-1:0] LUTRAM_ADDR_LAST = LUTRAM_ADDR_W'(LUTRAM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    CHECK,
    DRAIN,
    DONE
  } lutram_ctrl_state_t;

  // Cell i at address a holds pat[(a+i) mod 64]; the 6-bit sum wraps for free.
  function automatic logic lutram_exp(input logic [LUTRAM_DEPTH-1:0] pat,
                                      input int unsigned i,
                                      input logic [LUTRAM_ADDR_W-1:0] a);
    logic [LUTRAM_ADDR_W-1:0] idx;
    idx = a + LUTRAM_ADDR_W'(i);
    return pat[idx];
  endfunction

endpackage

// File: rtl/lutram_array_ctrl_cell_bank.sv
// Array of G_SIZE 64x1 single-port distributed RAM cells (async read, sync write),
// each kept as its own RAM64X1S-shaped primitive so bitstream analysis can find it.
module lutram_cell_bank
  import lutram_array_pkg::*;
#(
  parameter int G_SIZE = 4
) (
  input  logic                     clk,
  input  logic [LUTRAM_ADDR_W-1:0] ram_a,
  input  logic [G_SIZE-1:0]        ram_d,
  input  logic [G_SIZE-1:0]        ram_we,
  output logic [G_SIZE-1:0]        ram_o
);

  generate
    for (genvar gi = 0; gi < G_SIZE; gi++) begin : g_cell
      (* ram_style = "distributed", dont_touch = "true" *)
      logic mem_q [LUTRAM_DEPTH];

      always_ff @(posedge clk) begin
        if (ram_we[gi]) begin
          mem_q[ram_a] <= ram_d[gi];
        end
      end

      assign ram_o[gi] = mem_q[ram_a];
    end
  endgenerate

endmodule

// File: rtl/lutram_array_ctrl.sv
// Self-test sequencer: fills every LUTRAM cell with a shifted copy of a pattern, reads it back
// and reports pass/first-failure. LUTRAM_ARRAY_CTRL_ERRCNT_EN adds the err_cnt port and counter.
module lutram_array_ctrl
  import lutram_array_pkg::*;
#(
  parameter int G_SIZE = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [63:0]              pattern,
  output logic [LUTRAM_ADDR_W-1:0] ram_a,
  output logic [G_SIZE-1:0]        ram_d,
  output logic [G_SIZE-1:0]        ram_we,
  input  logic [G_SIZE-1:0]        ram_o,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [LUTRAM_ADDR_W-1:0] fail_addr,
  output logic [G_SIZE-1:0]        fail_mask
`ifdef LUTRAM_ARRAY_CTRL_ERRCNT_EN
  ,
  output logic [6:0]               err_cnt
`endif
);

  lutram_ctrl_state_t       state_q, state_d;
  logic [63:0]              pat_q, pat_d;
  logic [LUTRAM_ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [G_SIZE-1:0]        ram_d_q, ram_d_d;
  logic [G_SIZE-1:0]        ram_we_q, ram_we_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     pass_q, pass_d;
  logic [LUTRAM_ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [G_SIZE-1:0]        fail_mask_q, fail_mask_d;
  logic                     err_seen_q, err_seen_d;
  logic                     cmp_vld_q, cmp_vld_d;
  logic [LUTRAM_ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic [G_SIZE-1:0]        cmp_o_q, cmp_o_d;
  logic [G_SIZE-1:0]        cmp_exp_q, cmp_exp_d;
`ifdef LUTRAM_ARRAY_CTRL_ERRCNT_EN
  logic [6:0]               err_cnt_q, err_cnt_d;
`endif

  logic [G_SIZE-1:0] fill_exp;
  logic [G_SIZE-1:0] chk_exp;
  logic [G_SIZE-1:0] mismatch;

  // fill_exp targets the address being registered this edge; chk_exp the address being read now.
  generate
    for (genvar gi = 0; gi < G_SIZE; gi++) begin : g_exp
      assign fill_exp[gi] = lutram_exp(pat_d, gi, ram_a_d);
      assign chk_exp[gi]  = lutram_exp(pat_q, gi, ram_a_q);
    end
  endgenerate

  assign mismatch = cmp_vld_q ? (cmp_o_q ^ cmp_exp_q) : '0;

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    ram_a_d     = ram_a_q;
    ram_we_d    = '0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_mask_d = fail_mask_q;
    err_seen_d  = err_seen_q;
    cmp_vld_d   = 1'b0;
    cmp_addr_d  = ram_a_q;
    cmp_o_d     = ram_o;
    cmp_exp_d   = chk_exp;
`ifdef LUTRAM_ARRAY_CTRL_ERRCNT_EN
    err_cnt_d   = err_cnt_q;
`endif

    // Only the first mismatching address is recorded.
    if (|mismatch) begin
      if (!err_seen_q) begin
        fail_addr_d = cmp_addr_q;
        fail_mask_d = mismatch;
      end
      err_seen_d = 1'b1;
`ifdef LUTRAM_ARRAY_CTRL_ERRCNT_EN
      if (err_cnt_q != 7'd64) begin
        err_cnt_d = err_cnt_q + 7'd1;
      end
`endif
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FILL;
          pat_d       = pattern;
          ram_a_d     = '0;
          ram_we_d    = '1;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_mask_d = '0;
          err_seen_d  = 1'b0;
`ifdef LUTRAM_ARRAY_CTRL_ERRCNT_EN
          err_cnt_d   = '0;
`endif
        end
      end
      FILL: begin
        ram_a_d = ram_a_q + 6'd1;
        if (ram_a_q == LUTRAM_ADDR_LAST) begin
          state_d = CHECK;
        end else begin
          ram_we_d = '1;
        end
      end
      CHECK: begin
        cmp_vld_d = 1'b1;
        if (ram_a_q == LUTRAM_ADDR_LAST) begin
          state_d = DRAIN;
        end else begin
          ram_a_d = ram_a_q + 6'd1;
        end
      end
      DRAIN: begin
        // Address 63 is still in the compare stage, so fold it into pass here.
        state_d = DONE;
        done_d  = 1'b1;
        pass_d  = !(err_seen_q || (|mismatch));
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_d_d = '0;
    if (state_d == FILL) begin
      ram_d_d = fill_exp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      ram_a_q     <= '0;
      ram_d_q     <= '0;
      ram_we_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_mask_q <= '0;
      err_seen_q  <= 1'b0;
      cmp_vld_q   <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_o_q     <= '0;
      cmp_exp_q   <= '0;
`ifdef LUTRAM_ARRAY_CTRL_ERRCNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      ram_a_q     <= ram_a_d;
      ram_d_q     <= ram_d_d;
      ram_we_q    <= ram_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_mask_q <= fail_mask_d;
      err_seen_q  <= err_seen_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_o_q     <= cmp_o_d;
      cmp_exp_q   <= cmp_exp_d;
`ifdef LUTRAM_ARRAY_CTRL_ERRCNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign ram_a     = ram_a_q;
  assign ram_d     = ram_d_q;
  assign ram_we    = ram_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_mask = fail_mask_q;
`ifdef LUTRAM_ARRAY_CTRL_ERRCNT_EN
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_lutram_array_ctrl.sv
// Bench for lutram_array_ctrl driving a real cell bank, with read-path fault injection
// (stuck-at-0 cells, single-address bit flip) between the bank and the sequencer.
module tb_lutram_array_ctrl;
  import lutram_array_pkg::*;

  localparam int G = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [63:0]   pattern;
  logic [5:0]    ram_a;
  logic [G-1:0]  ram_d, ram_we, ram_o, bank_o;
  logic          busy, done, pass;
  logic [5:0]    fail_addr;
  logic [G-1:0]  fail_mask;
`ifdef LUTRAM_ARRAY_CTRL_ERRCNT_EN
  logic [6:0]    err_cnt;
`endif

  logic [G-1:0]  stuck_mask;
  logic          flip_en;
  logic [5:0]    flip_addr;
  logic [G-1:0]  flip_cell;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          pass;
    logic [5:0]    fail_addr;
    logic [G-1:0]  fail_mask;
    logic [6:0]    err_cnt;
  } exp_t;

  typedef struct {
    logic [63:0]   pat;
    logic [G-1:0]  stuck;
    logic          flip_en;
    logic [5:0]    flip_addr;
    logic [G-1:0]  flip_cell;
    exp_t          e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  assign ram_o = (bank_o & ~stuck_mask) ^ ((flip_en && ram_a == flip_addr) ? flip_cell : '0);

  lutram_cell_bank #(.G_SIZE(G)) u_bank (
    .clk    (clk),
    .ram_a  (ram_a),
    .ram_d  (ram_d),
    .ram_we (ram_we),
    .ram_o  (bank_o)
  );

  lutram_array_ctrl #(.G_SIZE(G)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .ram_a     (ram_a),
    .ram_d     (ram_d),
    .ram_we    (ram_we),
    .ram_o     (ram_o),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_mask (fail_mask)
`ifdef LUTRAM_ARRAY_CTRL_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ram_a"}, 64'(ram_a), 64'd0);
    chk({tag, " ram_d"}, 64'(ram_d), 64'd0);
    chk({tag, " ram_we"}, 64'(ram_we), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " pass"}, 64'(pass), 64'd0);
    chk({tag, " fail_addr"}, 64'(fail_addr), 64'd0);
    chk({tag, " fail_mask"}, 64'(fail_mask), 64'd0);
`ifdef LUTRAM_ARRAY_CTRL_ERRCNT_EN
    chk({tag, " err_cnt"}, 64'(err_cnt), 64'd0);
`endif
  endtask

  task automatic chk_result(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard: got done with empty queue want queued entry", tag);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, " pass"}, 64'(pass), 64'(e.pass));
    chk({tag, " fail_addr"}, 64'(fail_addr), 64'(e.fail_addr));
    chk({tag, " fail_mask"}, 64'(fail_mask), 64'(e.fail_mask));
`ifdef LUTRAM_ARRAY_CTRL_ERRCNT_EN
    chk({tag, " err_cnt"}, 64'(err_cnt), 64'(e.err_cnt));
`endif
  endtask

  // One full run: accept on the edge between the two negedges, then expect done 129 edges later.
  task automatic run_one(input logic [63:0] p, input exp_t e, input string tag);
    int cyc;
    sb_q.push_back(e);
    @(negedge clk);
    pattern = p;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy after accept"}, 64'(busy), 64'd1);
    cyc = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " done latency"}, 64'(cyc), 64'd129);
    if (done) chk_result(tag);
    else void'(sb_q.pop_front());
    @(negedge clk);
    chk({tag, " busy after done"}, 64'(busy), 64'd0);
    chk({tag, " done is a pulse"}, 64'(done), 64'd0);
  endtask

  function automatic exp_t mk(input logic p, input logic [5:0] a, input logic [G-1:0] m,
                              input logic [6:0] c);
    exp_t e;
    e.pass = p; e.fail_addr = a; e.fail_mask = m; e.err_cnt = c;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [63:0] pat, input logic [G-1:0] stuck,
                               input logic fe, input logic [5:0] fa, input logic [G-1:0] fc,
                               input exp_t e);
    vec_t v;
    v.pat = pat; v.stuck = stuck; v.flip_en = fe; v.flip_addr = fa; v.flip_cell = fc; v.e = e;
    return v;
  endfunction

  initial begin
    int   cyc;
    int   ndone;
    int   done_at [2];
    exp_t ok_e;
    logic [63:0] pa;

    ok_e = mk(1'b1, 6'd0, 4'b0000, 7'd0);
    vecs[0] = mkv(64'h0123_4567_89AB_CDEF, 4'b0000, 1'b0, 6'd0,  4'b0000, ok_e);
    vecs[1] = mkv(64'hFFFF_FFFF_FFFF_FFFF, 4'b0100, 1'b0, 6'd0,  4'b0000, mk(1'b0, 6'd0, 4'b0100, 7'd64));
    vecs[2] = mkv(64'h0,                   4'b0000, 1'b1, 6'd17, 4'b0001, mk(1'b0, 6'd17, 4'b0001, 7'd1));
    vecs[3] = mkv(64'h0,                   4'b0000, 1'b1, 6'd63, 4'b0001, mk(1'b0, 6'd63, 4'b0001, 7'd1));
    vecs[4] = mkv(64'h1,                   4'b1000, 1'b0, 6'd0,  4'b0000, mk(1'b0, 6'd61, 4'b1000, 7'd1));
    vecs[5] = mkv(64'h0,                   4'b0100, 1'b0, 6'd0,  4'b0000, ok_e);
    vecs[6] = mkv(64'h8000_0000_0000_0000, 4'b0001, 1'b1, 6'd61, 4'b0100, mk(1'b0, 6'd61, 4'b0100, 7'd2));
    vecs[7] = mkv(64'hA5C3_0F96_5A3C_F069, 4'b0000, 1'b0, 6'd0,  4'b0000, ok_e);

    rst = 1'b1; start = 1'b0; pattern = '0;
    stuck_mask = '0; flip_en = 1'b0; flip_addr = '0; flip_cell = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      stuck_mask = vecs[v].stuck;
      flip_en    = vecs[v].flip_en;
      flip_addr  = vecs[v].flip_addr;
      flip_cell  = vecs[v].flip_cell;
      run_one(vecs[v].pat, vecs[v].e, $sformatf("vec%0d", v));
      if (v == 0) chk("backdoor cell1 addr0", 64'(u_bank.g_cell[1].mem_q[0]), 64'd1);
    end
    stuck_mask = '0; flip_en = 1'b0;

    // Ignored starts at 5, 60 and 129 (done cycle); start right after done launches run two.
    sb_q.push_back(ok_e);
    sb_q.push_back(ok_e);
    @(negedge clk);
    pattern = 64'hDEAD_BEEF_0BAD_F00D;
    start   = 1'b1;
    @(negedge clk);
    cyc = 0; ndone = 0; done_at[0] = -1; done_at[1] = -1;
    while (cyc < 300) begin
      start = (cyc == 5 || cyc == 60 || cyc == 129 || cyc == 130);
      @(negedge clk);
      cyc++;
      if (done) begin
        if (ndone < 2) done_at[ndone] = cyc;
        ndone++;
        chk_result($sformatf("pulse run%0d", ndone));
      end
    end
    start = 1'b0;
    chk("pulse done count", 64'(ndone), 64'd2);
    chk("pulse first done", 64'(done_at[0]), 64'd129);
    chk("pulse second done", 64'(done_at[1]), 64'd260);
    while (sb_q.size() > 0) void'(sb_q.pop_front());

    // Reset while FILL is writing address 30.
    @(negedge clk);
    pattern = 64'h1357_9BDF_2468_ACE0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid fill ram_a", 64'(ram_a), 64'd30);
    chk("mid fill ram_we", 64'(ram_we), 64'hF);
    rst = 1'b1;
    #1;
    chk_reset_outputs("async rst");
    @(negedge clk);
    rst = 1'b0;
    run_one(64'h1357_9BDF_2468_ACE0, ok_e, "after rst");

    pa = 64'hF0E1_D2C3_B4A5_9687;
    run_one(pa, ok_e, "b2b A");
    run_one(~pa, ok_e, "b2b notA");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
